// File: rtl/rob_pr_free_q.sv
// rtl/rob_pr_free_q.sv - ROB-to-free-list PR return queue, per-bank dequeue
// Buffers commit bundles of dead PRs and steers each PR to its PRF bank's free list.
module rob_pr_free_q #(
   parameter int PR_COUNT       = 128,
   parameter int PRF_BANK_COUNT = 4,
   parameter int ENQ_WIDTH      = 4,
   parameter int QUEUE_ENTRIES  = 2,
   localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
   localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
   localparam int UPPER_W            = LOG_PR_COUNT - LOG_PRF_BANK_COUNT
) (
   input  logic                                 CLK,
   input  logic                                 nRST,
   input  logic                                 enq_valid,
   input  logic [ENQ_WIDTH-1:0]                 enq_free_mask,
   input  logic [ENQ_WIDTH*LOG_PR_COUNT-1:0]    enq_PR_by_lane,
   output logic                                 enq_ready,
   output logic [PRF_BANK_COUNT-1:0]            deq_valid_by_bank,
   output logic [PRF_BANK_COUNT*UPPER_W-1:0]    deq_upper_PR_by_bank,
   input  logic [PRF_BANK_COUNT-1:0]            deq_ready_by_bank
);

   localparam int LOG_Q = $clog2(QUEUE_ENTRIES);
   localparam int PTR_W = LOG_Q + 1;

   // Pointers carry one extra wrap bit above the index.
   logic [PTR_W-1:0]                  r_head;
   logic [PTR_W-1:0]                  r_tail;
   logic [ENQ_WIDTH-1:0]              r_mask [QUEUE_ENTRIES];
   logic [ENQ_WIDTH*LOG_PR_COUNT-1:0] r_pr   [QUEUE_ENTRIES];

   logic [LOG_Q-1:0]                  w_head_idx;
   logic [LOG_Q-1:0]                  w_tail_idx;
   logic                              w_empty;
   logic                              w_full;
   logic                              w_enq_fire;
   logic [ENQ_WIDTH-1:0]              w_head_mask;
   logic [ENQ_WIDTH*LOG_PR_COUNT-1:0] w_head_pr;
   logic [ENQ_WIDTH-1:0]              w_match [PRF_BANK_COUNT];
   logic [ENQ_WIDTH-1:0]              w_hit   [PRF_BANK_COUNT];
   logic [ENQ_WIDTH-1:0]              w_clr;
   logic [ENQ_WIDTH-1:0]              w_mask_next;
   logic [PRF_BANK_COUNT-1:0]         w_deq_valid;
   logic [PRF_BANK_COUNT*UPPER_W-1:0] w_deq_upper;

   assign w_head_idx  = r_head[LOG_Q-1:0];
   assign w_tail_idx  = r_tail[LOG_Q-1:0];
   assign w_empty     = (r_head == r_tail);
   assign w_full      = (w_head_idx == w_tail_idx) && (r_head[LOG_Q] != r_tail[LOG_Q]);
   assign enq_ready   = !w_full;
   assign w_enq_fire  = enq_valid && !w_full && (enq_free_mask != '0);
   assign w_head_mask = r_mask[w_head_idx];
   assign w_head_pr   = r_pr[w_head_idx];

   // Lowest pending lane per bank is isolated with the x & -x trick.
   always_comb begin
      w_clr       = '0;
      w_deq_valid = '0;
      w_deq_upper = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         w_match[b] = '0;
         for (int l = 0; l < ENQ_WIDTH; l++) begin
            w_match[b][l] = w_head_mask[l] &&
               (w_head_pr[l*LOG_PR_COUNT +: LOG_PRF_BANK_COUNT] == LOG_PRF_BANK_COUNT'(b));
         end
         w_hit[b] = w_match[b] & (~w_match[b] + ENQ_WIDTH'(1));
         if (!w_empty && (w_match[b] != '0)) begin
            w_deq_valid[b] = 1'b1;
            for (int l = 0; l < ENQ_WIDTH; l++) begin
               if (w_hit[b][l]) begin
                  w_deq_upper[b*UPPER_W +: UPPER_W] =
                     w_head_pr[l*LOG_PR_COUNT + LOG_PRF_BANK_COUNT +: UPPER_W];
               end
            end
            if (deq_ready_by_bank[b]) begin
               w_clr = w_clr | w_hit[b];
            end
         end
      end
      w_mask_next = w_head_mask & ~w_clr;
   end

   assign deq_valid_by_bank    = w_deq_valid;
   assign deq_upper_PR_by_bank = w_deq_upper;

   // Head and tail never write the same slot: equal indices mean empty (no retire) or full (no enqueue).
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_head <= '0;
         r_tail <= '0;
         for (int q = 0; q < QUEUE_ENTRIES; q++) begin
            r_mask[q] <= '0;
            r_pr[q]   <= '0;
         end
      end else begin
         if (!w_empty) begin
            r_mask[w_head_idx] <= w_mask_next;
            if (w_mask_next == '0) begin
               r_head <= r_head + PTR_W'(1);
            end
         end
         if (w_enq_fire) begin
            r_mask[w_tail_idx] <= enq_free_mask;
            r_pr[w_tail_idx]   <= enq_PR_by_lane;
            r_tail             <= r_tail + PTR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rob_pr_free_q.sv
// tb/tb_rob_pr_free_q.sv - directed and random checks of rob_pr_free_q against a bundle-queue model
module tb_rob_pr_free_q;

   localparam int QE = 2;

   typedef struct packed {
      logic [3:0]      pend;
      logic [3:0][6:0] pr;
   } bundle_t;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        enq_valid;
   logic [3:0]  enq_free_mask;
   logic [27:0] enq_PR_by_lane;
   logic        enq_ready;
   logic [3:0]  deq_valid_by_bank;
   logic [19:0] deq_upper_PR_by_bank;
   logic [3:0]  deq_ready_by_bank;

   int n_checks = 0;
   int n_errors = 0;
   int hs;
   bundle_t mq[$];

   rob_pr_free_q dut (
      .CLK                  (CLK),
      .nRST                 (nRST),
      .enq_valid            (enq_valid),
      .enq_free_mask        (enq_free_mask),
      .enq_PR_by_lane       (enq_PR_by_lane),
      .enq_ready            (enq_ready),
      .deq_valid_by_bank    (deq_valid_by_bank),
      .deq_upper_PR_by_bank (deq_upper_PR_by_bank),
      .deq_ready_by_bank    (deq_ready_by_bank)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Lowest pending lane whose PR lives in bank b, or -1.
   function automatic int pick(input bundle_t bd, input int b);
      for (int l = 0; l < 4; l++) begin
         if (bd.pend[l] && ((int'(bd.pr[l]) % 4) == b)) return l;
      end
      return -1;
   endfunction

   task automatic cyc(input logic rst_n, input logic v, input logic [3:0] m,
                      input logic [27:0] prs, input logic [3:0] rdy);
      logic [3:0]  ev;
      logic [19:0] eu;
      logic        er;
      int          ln;
      bundle_t     nb;
      ev = '0;
      eu = '0;
      er = (mq.size() < QE);
      if (mq.size() > 0) begin
         for (int b = 0; b < 4; b++) begin
            ln = pick(mq[0], b);
            if (ln >= 0) begin
               ev[b] = 1'b1;
               eu[b*5 +: 5] = 5'(int'(mq[0].pr[ln]) / 4);
            end
         end
      end
      check("deq_valid", 32'(deq_valid_by_bank), 32'(ev));
      check("deq_upper", 32'(deq_upper_PR_by_bank), 32'(eu));
      check("enq_ready", 32'(enq_ready), 32'(er));
      nRST              = rst_n;
      enq_valid         = v;
      enq_free_mask     = m;
      enq_PR_by_lane    = prs;
      deq_ready_by_bank = rdy;
      if (!rst_n) begin
         mq.delete();
      end else begin
         if (mq.size() > 0) begin
            nb = mq[0];
            for (int b = 0; b < 4; b++) begin
               if (ev[b] && rdy[b]) begin
                  ln = pick(nb, b);
                  nb.pend[ln] = 1'b0;
               end
            end
            mq[0] = nb;
            if (nb.pend == '0) void'(mq.pop_front());
         end
         if (v && er && (m != '0)) begin
            nb.pend = m;
            nb.pr   = prs;
            mq.push_back(nb);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; enq_valid = 1'b0; enq_free_mask = '0;
      enq_PR_by_lane = '0; deq_ready_by_bank = '0;
      @(posedge CLK);
      #1;
      check("rst_valid", 32'(deq_valid_by_bank), 32'h0);
      check("rst_upper", 32'(deq_upper_PR_by_bank), 32'h0);
      check("rst_ready", 32'(enq_ready), 32'h1);

      // All four banks in one bundle
      cyc(1, 1, 4'hF, {7'd19, 7'd14, 7'd9, 7'd4}, 4'hF);
      check("t1_valid", 32'(deq_valid_by_bank), 32'hF);
      check("t1_upper", 32'(deq_upper_PR_by_bank), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
      cyc(1, 0, 4'h0, 28'h0, 4'hF);
      check("t1_empty", 32'(deq_valid_by_bank), 32'h0);
      check("t1_ready", 32'(enq_ready), 32'h1);

      // Three lanes on bank 0 serialize
      cyc(1, 1, 4'b0111, {7'd0, 7'd16, 7'd12, 7'd8}, 4'hF);
      check("t2_up0", 32'(deq_upper_PR_by_bank[4:0]), 32'd2);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);
      check("t2_up1", 32'(deq_upper_PR_by_bank[4:0]), 32'd3);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);
      check("t2_up2", 32'(deq_upper_PR_by_bank[4:0]), 32'd4);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);
      check("t2_done", 32'(deq_valid_by_bank), 32'h0);

      // Backpressure fills the queue
      cyc(1, 1, 4'b0001, {21'd0, 7'd5}, 4'h0);
      cyc(1, 1, 4'b0001, {21'd0, 7'd6}, 4'h0);
      check("t3_full", 32'(enq_ready), 32'h0);
      cyc(1, 1, 4'b0001, {21'd0, 7'd7}, 4'h0);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);
      check("t3_reopen", 32'(enq_ready), 32'h1);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);

      // Zero-mask bundle is dropped
      cyc(1, 1, 4'h0, {7'd1, 7'd2, 7'd3, 7'd4}, 4'hF);
      check("t4_valid", 32'(deq_valid_by_bank), 32'h0);
      check("t4_ready", 32'(enq_ready), 32'h1);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);

      // Streaming through pointer wrap
      hs = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(1, (i < 5), 4'b0001, {21'd0, 7'd127}, 4'hF);
         if (deq_valid_by_bank[3] && (deq_upper_PR_by_bank[19:15] == 5'd31)) hs++;
      end
      check("t5_handshakes", 32'(hs), 32'd5);

      // Reset mid-drain
      cyc(1, 1, 4'b0011, {14'd0, 7'd8, 7'd4}, 4'h0);
      cyc(1, 1, 4'b0001, {21'd0, 7'd12}, 4'h0);
      cyc(0, 0, 4'h0, 28'h0, 4'h0);
      check("t6_valid", 32'(deq_valid_by_bank), 32'h0);
      check("t6_ready", 32'(enq_ready), 32'h1);
      cyc(1, 0, 4'h0, 28'h0, 4'hF);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] rdy;
         for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(9) < 7);
         cyc(($urandom_range(99) != 0), 1'($urandom), 4'($urandom), 28'($urandom), rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
